// File: rtl/handshake_sync_arbiter.sv
// Round-robin arbiter that shares one handshake_sync CDC channel among N_REQ
// source-domain requesters, with a sticky watchdog for a channel that never answers.
module handshake_sync_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_REQ*DATA_W-1:0]  req_data_i,
  input  logic [N_REQ-1:0]         req_val_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [DATA_W-1:0]        sync_data_o,
  output logic                     sync_val_o,
  input  logic                     sync_ready_i,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LOW,
    WAIT_HIGH,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                val_q, val_d;
  logic [N_REQ-1:0]    ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  int                  scan_idx;
  logic [ID_W-1:0]     next_ptr;
  logic [WD_W-1:0]     wd_inc;
  logic                wd_hit;
  logic                abort;

  // Rotating priority scan starting at ptr_q, wrapping at N_REQ-1.
  always_comb begin
    // NOTE: every comb-assigned signal gets a default first so no path infers a latch.
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!pick_found && req_val_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(scan_idx);
      end
    end
  end

  assign next_ptr = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
  assign wd_inc   = wd_q + WD_W'(1);
  assign wd_hit   = WD_EN && (wd_inc == WD_W'(TIMEOUT));

  // State register plus the registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      val_q     <= 1'b0;
      ready_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      val_q     <= val_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  // Next-state, rotation pointer and watchdog counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A busy channel (ready low) is never handed a new word.
        if (pick_found && sync_ready_i) begin
          state_d = LAUNCH;
          wd_d    = '0;
        end
      end
      LAUNCH: state_d = WAIT_LOW;
      WAIT_LOW: begin
        wd_d = wd_inc;
        if (wd_hit)             abort   = 1'b1;
        else if (!sync_ready_i) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        wd_d = wd_inc;
        if (sync_ready_i) state_d = DONE;
        else if (wd_hit)  abort   = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = next_ptr;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      ptr_d   = next_ptr;
    end
  end

  // Output next values; data is captured only on a grant and held afterwards.
  always_comb begin
    grant_d   = grant_q;
    data_d    = data_q;
    val_d     = 1'b0;
    ready_d   = '0;
    busy_d    = (state_d != IDLE);
    timeout_d = timeout_q | abort;
    if (state_q == IDLE && state_d == LAUNCH) begin
      grant_d = pick_id;
      data_d  = req_data_i[int'(pick_id)*DATA_W +: DATA_W];
      val_d   = 1'b1;
    end
    if (state_d == DONE) ready_d[grant_q] = 1'b1;
  end

  assign req_ready_o = ready_q;
  assign sync_data_o = data_q;
  assign sync_val_o  = val_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_handshake_sync_arbiter.sv
// Scoreboard bench for handshake_sync_arbiter: expected launches and completions
// are queued by the stimulus and consumed by a monitor when the DUT presents them.
module tb_handshake_sync_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 16;

  typedef enum int { CH_NORMAL, CH_LOW, CH_HIGH } ch_mode_e;
  typedef struct { logic [1:0] id; logic [15:0] data; } launch_t;
  typedef struct { logic [3:0] rdy; logic [15:0] data; } done_t;

  logic                    clk_i;
  logic                    rst_n_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_val_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]       sync_data_o;
  logic                    sync_val_o;
  logic                    sync_ready_i;
  logic [1:0]              grant_id_o;
  logic                    busy_o;
  logic                    timeout_o;

  ch_mode_e ch_mode;
  int       ch_cnt;
  int       n_checks;
  int       n_fail;
  launch_t  exp_launch[$];
  done_t    exp_done[$];

  handshake_sync_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_data_i   (req_data_i),
    .req_val_i    (req_val_i),
    .req_ready_o  (req_ready_o),
    .sync_data_o  (sync_data_o),
    .sync_val_o   (sync_val_o),
    .sync_ready_i (sync_ready_i),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Channel model: drops ready after a launch, restores it six cycles later.
  initial begin
    sync_ready_i = 1'b1;
    ch_cnt       = 0;
    forever begin
      @(negedge clk_i);
      case (ch_mode)
        CH_LOW:  begin sync_ready_i = 1'b0; ch_cnt = 0; end
        CH_HIGH: begin sync_ready_i = 1'b1; ch_cnt = 0; end
        default: begin
          if (ch_cnt > 0) begin
            ch_cnt = ch_cnt - 1;
            if (ch_cnt == 0) sync_ready_i = 1'b1;
          end else if (sync_val_o) begin
            sync_ready_i = 1'b0;
            ch_cnt       = 6;
          end else begin
            sync_ready_i = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_launch(input logic [1:0] id, input logic [15:0] data);
    launch_t l;
    l.id = id; l.data = data;
    exp_launch.push_back(l);
  endtask

  task automatic expect_done(input logic [3:0] rdy, input logic [15:0] data);
    done_t d;
    d.rdy = rdy; d.data = data;
    exp_done.push_back(d);
  endtask

  task automatic monitor();
    launch_t l;
    done_t   d;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        if (sync_val_o) begin
          check("launch_expected", 32'(exp_launch.size() != 0), 1);
          if (exp_launch.size() != 0) begin
            l = exp_launch.pop_front();
            check("launch_id", 32'(grant_id_o), 32'(l.id));
            check("launch_data", 32'(sync_data_o), 32'(l.data));
          end
        end
        if (req_ready_o != '0) begin
          check("done_expected", 32'(exp_done.size() != 0), 1);
          if (exp_done.size() != 0) begin
            d = exp_done.pop_front();
            check("done_vector", 32'(req_ready_o), 32'(d.rdy));
            check("done_data", 32'(sync_data_o), 32'(d.data));
          end
        end
      end
    end
  endtask

  task automatic wait_launch();
    int n = 0;
    do begin @(negedge clk_i); n++; end while (!sync_val_o && n < 60);
    check("wait_launch", 32'(sync_val_o), 1);
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    do begin @(negedge clk_i); n++; end while (!req_ready_o[k] && n < 60);
    check($sformatf("wait_ready%0d", k), 32'(req_ready_o[k]), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sync_val"},  32'(sync_val_o),  0);
    check({tag, "_sync_data"}, 32'(sync_data_o), 0);
    check({tag, "_req_ready"}, 32'(req_ready_o), 0);
    check({tag, "_grant_id"},  32'(grant_id_o),  0);
    check({tag, "_busy"},      32'(busy_o),      0);
    check({tag, "_timeout"},   32'(timeout_o),   0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    ch_mode    = CH_NORMAL;
    rst_n_i    = 1'b0;
    req_val_i  = '0;
    req_data_i = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Single requester 1; one-cycle grant latency, ptr moves to 2.
    req_data_i = {16'h4444, 16'h3333, 16'hBEEF, 16'h1111};
    expect_launch(2'd1, 16'hBEEF);
    expect_done(4'b0010, 16'hBEEF);
    req_val_i = 4'b0010;
    @(negedge clk_i);
    check("grant_latency", 32'(sync_val_o), 1);
    check("busy_launch", 32'(busy_o), 1);
    wait_ready(1);
    req_val_i = '0;
    @(negedge clk_i);
    check("ready_one_cycle", 32'(req_ready_o), 0);
    check("idle_after_done", 32'(busy_o), 0);
    check("grant_id_held", 32'(grant_id_o), 1);
    check("data_held", 32'(sync_data_o), 32'h0000_BEEF);

    // Fairness from ptr=2 with requesters 0 and 3: 3 wins, then 0.
    req_data_i = {16'h3003, 16'h2002, 16'h1001, 16'h0AA0};
    expect_launch(2'd3, 16'h3003);
    expect_done(4'b1000, 16'h3003);
    expect_launch(2'd0, 16'h0AA0);
    expect_done(4'b0001, 16'h0AA0);
    req_val_i = 4'b1001;
    wait_ready(3);
    req_val_i[3] = 1'b0;
    wait_ready(0);
    req_val_i[0] = 1'b0;

    // Requester 1 scrambles its data and drops val after the grant.
    req_data_i[31:16] = 16'h1234;
    expect_launch(2'd1, 16'h1234);
    expect_done(4'b0010, 16'h1234);
    req_val_i = 4'b0010;
    wait_launch();
    req_val_i[1] = 1'b0;
    for (int n = 0; n < 40 && !req_ready_o[1]; n++) begin
      req_data_i[31:16] = 16'h5A5A ^ 16'(n * 257);
      @(negedge clk_i);
    end
    check("val_drop_still_done", 32'(req_ready_o[1]), 1);
    for (int n = 0; n < 3; n++) begin
      req_data_i[31:16] = 16'hF00F + 16'(n);
      @(negedge clk_i);
      check("data_stable_after_done", 32'(sync_data_o), 32'h0000_1234);
    end

    // Reset in WAIT_HIGH clears outputs asynchronously; no grant while ready low.
    req_data_i[47:32] = 16'h2222;
    expect_launch(2'd2, 16'h2222);
    req_val_i = 4'b0100;
    wait_launch();
    repeat (3) @(negedge clk_i);
    check("busy_wait_high", 32'(busy_o), 1);
    check("no_ready_yet", 32'(req_ready_o), 0);
    #1 rst_n_i = 1'b0;
    ch_mode   = CH_LOW;
    req_val_i = '0;
    #1 check_reset_outputs("async_rst");
    req_data_i = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req_val_i  = 4'b1111;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      check("no_grant_ready_low", 32'(busy_o), 0);
    end

    // All four requesting continuously: 0,1,2,3,0.
    expect_launch(2'd0, 16'hD000); expect_done(4'b0001, 16'hD000);
    expect_launch(2'd1, 16'hD001); expect_done(4'b0010, 16'hD001);
    expect_launch(2'd2, 16'hD002); expect_done(4'b0100, 16'hD002);
    expect_launch(2'd3, 16'hD003); expect_done(4'b1000, 16'hD003);
    expect_launch(2'd0, 16'hD000); expect_done(4'b0001, 16'hD000);
    ch_mode = CH_NORMAL;
    wait_ready(0);
    wait_ready(1);
    wait_ready(2);
    wait_ready(3);
    wait_ready(0);
    req_val_i = '0;

    // Watchdog: ready stuck high, abort after 8 WAIT_LOW cycles, next grant rotates.
    ch_mode           = CH_HIGH;
    req_data_i[31:16] = 16'hC001;
    req_data_i[47:32] = 16'hC002;
    expect_launch(2'd1, 16'hC001);
    req_val_i = 4'b0110;
    wait_launch();
    repeat (8) @(negedge clk_i);
    check("timeout_not_early", 32'(timeout_o), 0);
    check("busy_in_wait_low", 32'(busy_o), 1);
    @(negedge clk_i);
    check("timeout_set", 32'(timeout_o), 1);
    check("idle_after_timeout", 32'(busy_o), 0);
    ch_mode = CH_NORMAL;
    expect_launch(2'd2, 16'hC002); expect_done(4'b0100, 16'hC002);
    expect_launch(2'd1, 16'hC001); expect_done(4'b0010, 16'hC001);
    wait_ready(2);
    req_val_i[2] = 1'b0;
    wait_ready(1);
    req_val_i[1] = 1'b0;
    @(negedge clk_i);
    check("timeout_sticky", 32'(timeout_o), 1);
    check("launch_queue_drained", 32'(exp_launch.size()), 0);
    check("done_queue_drained", 32'(exp_done.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_sync_arbiter.md
# handshake_sync_arbiter

Round-robin arbiter and sequencer that shares one `handshake_sync` clock-domain-crossing channel among `N_REQ` requesters in the channel's source clock domain. It grants one requester at a time and latches that requester's word. It drives the channel's valid/data inputs and tracks the channel's ready to completion, then acknowledges the granted requester. A timeout watchdog flags a channel that never responds.

## Interface
- `N_REQ`, 4: number of requesters, 2..16
- `DATA_W`, 16: payload width, equal to the shared channel's `DATA_W`
- `TIMEOUT`, 255: maximum cycles spent waiting in WAIT_LOW plus WAIT_HIGH; 0 disables the watchdog

- `clk_i` in 1: single clock, the channel's source-domain clock
- `rst_n_i` in 1: reset, asynchronous, active-low
- `req_data_i` in N_REQ*DATA_W: requester k payload occupies bits [k*DATA_W +: DATA_W]
- `req_val_i` in N_REQ: per-requester request, held until acknowledged
- `req_ready_o` out N_REQ: one-cycle completion pulse to the granted requester
- `sync_data_o` out DATA_W: payload to the channel's `data_a_i`
- `sync_val_o` out 1: launch strobe to the channel's `data_a_val_i`
- `sync_ready_i` in 1: the channel's `data_a_ready_o`
- `grant_id_o` out $clog2(N_REQ): index of the current or last grant
- `busy_o` out 1: high in every state except IDLE
- `timeout_o` out 1: sticky watchdog flag

## Operation
- FSM states: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE:
  - If `|req_val_i` and `sync_ready_i` are both high, pick the winner: the first set bit of `req_val_i` scanning from `ptr` upward, wrapping at N_REQ-1 to 0.
  - On a pick, register `grant_id_o`, capture the winner's slice into `sync_data_o`, and go to LAUNCH.
- LAUNCH: `sync_val_o`=1 for exactly this cycle; go to WAIT_LOW.
- WAIT_LOW: wait until `sync_ready_i`=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait until `sync_ready_i`=1, then go to DONE.
- DONE:
  - `req_ready_o[grant_id_o]`=1 for this cycle only.
  - `ptr` <= grant_id_o+1, wrapping to 0 at N_REQ.
  - Go to IDLE.
- `sync_data_o` changes only on a grant; it is held stable from grant through DONE and afterwards, because the far domain samples it late.
- Requester inputs are ignored after the grant:
  - A change to `req_data_i` after the grant has no effect.
  - If `req_val_i[grant]` drops after the grant, the transaction still completes and DONE still pulses.
- Watchdog:
  - Counter width $clog2(TIMEOUT+1).
  - Cleared on entry to LAUNCH; increments each cycle in WAIT_LOW and WAIT_HIGH.
  - When it reaches TIMEOUT: set `timeout_o`, skip the `req_ready_o` pulse, set `ptr` <= grant_id_o+1, go to IDLE.
  - The aborted requester keeps its `req_val_i` and is re-arbitrated later.
  - `timeout_o` clears only on reset.
- No request is ever granted while `sync_ready_i`=0 in IDLE.

## Timing
- Reset values: state IDLE, `ptr`=0, `sync_val_o`=0, `sync_data_o`=0, `req_ready_o`=0, `grant_id_o`=0, `busy_o`=0, `timeout_o`=0, watchdog counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Grant latency: with `req_val_i` high in IDLE at cycle t, `sync_val_o`=1 at cycle t+1 (LAUNCH).
- `req_ready_o` pulses one cycle after `sync_ready_i` is first seen high in WAIT_HIGH.
- Consecutive transactions: at least one IDLE cycle follows DONE. A requester dropping `req_val_i` the cycle after its pulse is never granted twice.
- Simultaneous requests: exactly one grant per transaction, chosen by rotation. No requester waits more than N_REQ-1 other transactions.
- Reset asserted mid-transaction:
  - Outputs return to reset values immediately, asynchronously.
  - The channel may still be busy; after release, IDLE waits for `sync_ready_i`=1 before granting.

## Test plan
- Single requester: `req_val_i`=4'b0010, `req_data_i[31:16]`=16'hBEEF, channel model drops ready 1 cycle after val and restores it 6 cycles later -> one `sync_val_o` pulse, `sync_data_o`=16'hBEEF held, `req_ready_o`=4'b0010 for one cycle, `ptr`=2.
- All four requesting continuously from reset -> grants in order 0,1,2,3,0, each with one `sync_val_o` pulse and a matching `req_ready_o` pulse.
- Fairness: with `ptr`=2 and only requesters 0 and 3 active -> grant 3 first, then 0.
- Watchdog: with TIMEOUT=8 and `sync_ready_i` stuck at 1 after launch -> after 8 cycles in WAIT_LOW, `timeout_o`=1, no `req_ready_o` pulse, state IDLE, and the next grant goes to the following requester.
- `rst_n_i` pulsed low during WAIT_HIGH -> all outputs reset within the same cycle. After release with `sync_ready_i` low, no grant occurs until it returns high.
- `req_data_i` of the granted requester changed every cycle after grant -> `sync_data_o` stays at the captured value until the next grant.
